totient_sequencer: RTL and testbench
====================================

Name: totient_sequencer

Overview:
- Controller that sequences the 4-bit index into the Euler's totient ROM/7-segment display path.
- Replaces the free-running per-clock counter with a run/pause/single-step FSM, a programmable dwell time per digit, an up/down direction control and a one-shot stop at the end of the table.
- Output `idx` drives the ROM address. `tick` and `wrap` are available to the surrounding display logic.

Parameters:
- DWELL_W, 16, width of the dwell count input and the internal dwell counter.
- LAST_IDX, 15, highest ROM index. Legal range is 1..15; index arithmetic is 4-bit.

Ports:
- clk_0  input  1  system clock; all state updates on the rising edge.
- R  input  1  reset, asynchronous, active-low.
- start  input  1  level, synchronous; its rising edge requests run.
- stop  input  1  level, synchronous; its rising edge requests pause/home.
- step  input  1  level, synchronous; its rising edge requests a single advance while idle.
- oneshot  input  1  1 = halt at the end of the table; 0 = wrap continuously.
- dir  input  1  0 = count up, 1 = count down. Sampled at every advance.
- dwell  input  DWELL_W  cycles to hold each index. Hold period is dwell+1 cycles. Sampled live.
- idx  output  4  current ROM index (registered).
- run  output  1  high while the FSM is in RUN.
- tick  output  1  one-cycle pulse, asserted in the same cycle `idx` takes its new value.
- wrap  output  1  one-cycle pulse when `idx` wraps (LAST_IDX->0 up, 0->LAST_IDX down). Coincides with `tick`.
- done  output  1  level, high while the FSM is in DONE.

Behaviour:
- Reset (R=0, asynchronous):
  - State = IDLE, idx = 0, dwell counter = 0.
  - run = tick = wrap = done = 0.
  - Edge-detect history registers = 0, so an input already high when reset releases counts as a rising edge.
- Edge detection:
  - Event = input is 1 this cycle and was 0 at the previous clock.
  - One event per rising edge; holding an input high produces no repeats.
- Simultaneous events: priority stop > start > step; lower-priority events in that cycle are dropped.
- Home position: 0 if dir=0, LAST_IDX if dir=1 (dir sampled when homing).
- End position: LAST_IDX if dir=0, 0 if dir=1.
- Advance:
  - dir=0: idx = (idx == LAST_IDX) ? 0 : idx+1.
  - dir=1: idx = (idx == 0) ? LAST_IDX : idx-1.
  - tick=1 in the cycle idx updates; wrap=1 additionally on the wrap transition.
- States:
  - IDLE:
    - start -> RUN; idx held; counter cleared.
    - step -> one advance, stay IDLE. If oneshot=1 and idx is at the end position, step is ignored (no tick).
    - stop -> idx loaded with home position; no tick.
  - RUN:
    - Counter increments each cycle.
    - When counter >= dwell: counter cleared and an advance is performed. First advance occurs dwell+1 cycles after entering RUN.
    - With dwell=0, advance every cycle.
    - If dwell is lowered below the current counter, the advance happens on the next compare.
    - oneshot=1 and idx at end position at an advance -> no idx change, no tick, no wrap; go DONE.
    - stop -> IDLE; idx held; counter cleared. A pending advance in that same cycle is suppressed.
    - start/step ignored.
  - DONE:
    - done=1, idx held.
    - start -> idx = home, counter cleared, RUN.
    - stop -> idx = home, IDLE.
    - step ignored.
- dir or oneshot changed mid-run takes effect at the next advance; no restart.
- Reset asserted mid-operation returns everything to reset values immediately, independent of clk_0.
- run and done are registered state decodes: they change in the cycle after the transition edge.

Test Plan:
- Reset release, dwell=2, dir=0, oneshot=0, start pulse:
  - run=1 next cycle.
  - idx steps 0->1->2… every 3 cycles with tick each time.
  - At 15->0: wrap=1 with tick.
- Same run, stop pulse at idx=5 mid-dwell: IDLE, run=0, idx stays 5, no further ticks. Second stop pulse -> idx=0.
- IDLE at idx=0, dir=1, step pulses x3:
  - idx 15, 14, 13.
  - wrap only on the first step.
  - Holding step high for 10 cycles gives exactly one advance.
- oneshot=1, dwell=0, dir=0, start from idx=0:
  - idx reaches 15 after 15 ticks.
  - Next compare: no tick, done=1, run=0.
  - start -> idx=0, done=0, RUN.
- start and stop rising in the same cycle while IDLE at idx=7: stop wins, idx=0, state IDLE.
- R pulsed low asynchronously mid-RUN at idx=9: idx=0, run=0, tick=0 without a clock edge; after release the FSM stays IDLE until the next start edge.

Source files
------------

// File: rtl/totient_sequencer.sv
// Index sequencer for the totient ROM / 7-segment path: run, pause and single-step
// control with a programmable dwell per digit, direction select and one-shot stop.
module totient_sequencer #(
  parameter int DWELL_W  = 16,
  parameter int LAST_IDX = 15
) (
  input  logic               clk_0,
  input  logic               R,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               oneshot,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         idx,
  output logic               run,
  output logic               tick,
  output logic               wrap,
  output logic               done
);

  localparam logic [3:0] LAST = 4'(LAST_IDX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic               start_q, stop_q, step_q;

  logic       start_ev, stop_ev, step_ev;
  logic [3:0] home_idx;
  logic       at_end;
  logic [3:0] adv_idx;
  logic       adv_wrap;

  // NOTE: every signal gets a value before any branch so always_comb never infers a latch.
  always_comb begin
    start_ev = start & ~start_q;
    stop_ev  = stop  & ~stop_q;
    step_ev  = step  & ~step_q;
    home_idx = dir ? LAST : 4'd0;
    at_end   = dir ? (idx == 4'd0) : (idx == LAST);
    adv_idx  = idx;
    adv_wrap = 1'b0;
    if (dir) begin
      adv_wrap = (idx == 4'd0);
      adv_idx  = adv_wrap ? LAST : idx - 4'd1;
    end else begin
      adv_wrap = (idx == LAST);
      adv_idx  = adv_wrap ? 4'd0 : idx + 4'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; tick/wrap default low and are raised only on an advance.
  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      state   <= S_IDLE;
      idx     <= 4'd0;
      cnt     <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      step_q  <= 1'b0;
      run     <= 1'b0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      step_q  <= step;
      tick    <= 1'b0;
      wrap    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (stop_ev) begin
            idx <= home_idx;
          end else if (start_ev) begin
            state <= S_RUN;
            run   <= 1'b1;
            cnt   <= '0;
          end else if (step_ev && !(oneshot && at_end)) begin
            idx  <= adv_idx;
            tick <= 1'b1;
            wrap <= adv_wrap;
          end
        end

        S_RUN: begin
          if (stop_ev) begin
            state <= S_IDLE;
            run   <= 1'b0;
            cnt   <= '0;
          end else if (cnt >= dwell) begin
            // >= rather than == so a dwell lowered below the count still fires.
            cnt <= '0;
            if (oneshot && at_end) begin
              state <= S_DONE;
              run   <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx  <= adv_idx;
              tick <= 1'b1;
              wrap <= adv_wrap;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (stop_ev) begin
            idx   <= home_idx;
            state <= S_IDLE;
            done  <= 1'b0;
          end else if (start_ev) begin
            idx   <= home_idx;
            cnt   <= '0;
            state <= S_RUN;
            run   <= 1'b1;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          run   <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_totient_sequencer.sv
// Directed and randomized bench for totient_sequencer against a cycle-level model
// that tracks mode, index and dwell count with plain integer arithmetic.
module tb_totient_sequencer;

  localparam int DW   = 16;
  localparam int LAST = 15;

  logic          clk_0 = 1'b0;
  logic          R = 1'b0;
  logic          start = 1'b0, stop = 1'b0, step = 1'b0;
  logic          oneshot = 1'b0, dir = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [3:0]    idx;
  logic          run, tick, wrap, done;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: mode 0=idle, 1=run, 2=done
  int m_mode = 0, m_idx = 0, m_cnt = 0;
  bit m_tick = 0, m_wrap = 0;
  bit p_start = 0, p_stop = 0, p_step = 0;

  totient_sequencer #(.DWELL_W(DW), .LAST_IDX(LAST)) dut (
    .clk_0(clk_0), .R(R), .start(start), .stop(stop), .step(step),
    .oneshot(oneshot), .dir(dir), .dwell(dwell),
    .idx(idx), .run(run), .tick(tick), .wrap(wrap), .done(done)
  );

  always #5 clk_0 = ~clk_0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("idx", int'(idx), m_idx);
    check("run", int'(run), int'(m_mode == 1));
    check("done", int'(done), int'(m_mode == 2));
    check("tick", int'(tick), int'(m_tick));
    check("wrap", int'(wrap), int'(m_wrap));
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    p_start = 0; p_stop = 0; p_step = 0;
  endtask

  task automatic model_advance();
    m_tick = 1;
    m_wrap = dir ? (m_idx == 0) : (m_idx == LAST);
    m_idx  = dir ? (m_idx + LAST) % (LAST + 1) : (m_idx + 1) % (LAST + 1);
  endtask

  task automatic model_step();
    bit e_start, e_stop, e_step;
    int home, end_pos;
    e_start = start && !p_start;
    e_stop  = stop && !p_stop;
    e_step  = step && !p_step;
    p_start = start; p_stop = stop; p_step = step;
    home    = dir ? LAST : 0;
    end_pos = dir ? 0 : LAST;
    m_tick  = 0;
    m_wrap  = 0;
    if (m_mode == 0) begin
      if (e_stop) m_idx = home;
      else if (e_start) begin m_mode = 1; m_cnt = 0; end
      else if (e_step && !(oneshot && m_idx == end_pos)) model_advance();
    end else if (m_mode == 1) begin
      if (e_stop) begin m_mode = 0; m_cnt = 0; end
      else if (m_cnt >= int'(dwell)) begin
        m_cnt = 0;
        if (oneshot && m_idx == end_pos) m_mode = 2;
        else model_advance();
      end else m_cnt++;
    end else begin
      if (e_stop) begin m_idx = home; m_mode = 0; end
      else if (e_start) begin m_idx = home; m_cnt = 0; m_mode = 1; end
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_0);
      model_step();
      #1;
      check_all();
    end
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && m_idx != target; i++) cyc();
    check("reach_idx", int'(idx), target);
  endtask

  int tick_count;

  initial begin
    // reset state while R is held low
    #3;
    check("rst_idx", int'(idx), 0);
    check("rst_run", int'(run), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(tick), 0);
    #5 R = 1'b1;

    // free run, dwell=2, wraps 15->0
    dwell = 2; dir = 0; oneshot = 0;
    start = 1; cyc(); start = 0;
    check("run_after_start", int'(run), 1);
    tick_count = 0;
    for (int i = 0; i < 52; i++) begin
      cyc();
      if (tick) tick_count++;
    end
    check("ticks_52_cycles", tick_count, 17);

    // stop mid-dwell at idx 5, then home
    run_until(5, 80);
    cyc();
    stop = 1; cyc(); stop = 0;
    cyc(6);
    check("held_idx", int'(idx), 5);
    stop = 1; cyc(); stop = 0; cyc();
    check("homed_idx", int'(idx), 0);

    // single steps downward; held step gives one advance
    dir = 1;
    for (int i = 0; i < 3; i++) begin
      step = 1; cyc(); step = 0; cyc();
    end
    check("step_idx", int'(idx), 13);
    step = 1; cyc(10); step = 0; cyc();
    check("held_step_idx", int'(idx), 12);

    // one-shot to the end of the table
    dir = 0;
    stop = 1; cyc(); stop = 0; cyc();
    oneshot = 1; dwell = 0;
    start = 1; cyc(); start = 0;
    cyc(20);
    check("oneshot_done", int'(done), 1);
    check("oneshot_idx", int'(idx), 15);
    start = 1; cyc(); start = 0;
    check("restart_idx", int'(idx), 0);
    cyc(3);
    stop = 1; cyc(); stop = 0; cyc();
    oneshot = 0;

    // simultaneous start and stop while idle at 7
    stop = 1; cyc(); stop = 0; cyc();
    for (int i = 0; i < 7; i++) begin
      step = 1; cyc(); step = 0; cyc();
    end
    check("pre_tie_idx", int'(idx), 7);
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    cyc(3);
    check("tie_idx", int'(idx), 0);
    check("tie_run", int'(run), 0);

    // asynchronous reset mid-run at idx 9
    dwell = 1;
    start = 1; cyc(); start = 0;
    run_until(9, 60);
    #2 R = 1'b0;
    #1;
    model_reset();
    check("async_idx", int'(idx), 0);
    check("async_run", int'(run), 0);
    check("async_tick", int'(tick), 0);
    #1 R = 1'b1;
    cyc(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom % 24) == 0;
      stop  = ($urandom % 60) == 0;
      step  = ($urandom % 6) == 0;
      if (($urandom % 16) == 0) dir = ~dir;
      if (($urandom % 40) == 0) oneshot = ~oneshot;
      dwell = DW'($urandom % 4);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
